// File: rtl/muldiv_engine.sv
// -----------------------------------------------------------------------------
// muldiv_engine
//
// Single-issue multiply/divide engine sitting between the execute stage and
// the HI/LO writeback. One request is accepted at a time over a valid/ready
// handshake. The result is held in registers until it is consumed.
//
//   mul : {out_res1, out_res0} = full 2*WIDTH product, signed or unsigned.
//         out_valid rises MUL_STAGES cycles after accept.
//   div : out_res0 = quotient (truncated toward zero),
//         out_res1 = remainder (takes the sign of the dividend).
//         Iterative radix-2 restoring divider: one step per cycle, then one
//         sign fix-up cycle. Divide by zero and signed overflow bypass the
//         loop and complete one cycle after accept.
//   nop / reserved : accepted, no result is produced.
//
// Parameters
//   WIDTH       operand width, even and >= 8
//   MUL_STAGES  multiply latency in cycles, 1..4
//
// Build option
//   MULDIV_EARLY_OUT_EN  when defined, the dividend is pre-shifted by its
//                        leading-zero count so the loop runs only over its
//                        significant bits (minimum one step). Results are
//                        identical with or without it; only latency changes.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   flush                 synchronous abort of any in-flight operation/result
//   in_src0, in_src1      multiplicand/dividend, multiplier/divisor
//   in_op, in_sign        0 nop, 1 mul, 2 div, 3 reserved; 1 = signed operands
//   in_valid, in_ready    request handshake
//   out_valid, out_ready  result handshake
//   out_res0, out_res1    product low/high, or quotient/remainder
//   busy                  engine is not idle
// -----------------------------------------------------------------------------
module muldiv_engine #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_src0,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [1:0]       in_op,
  input  logic             in_sign,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res0,
  output logic [WIDTH-1:0] out_res1,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd2;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CW-1:0]    cnt;       // multiply stages or divide steps still to run
  logic [WIDTH-1:0] res0, res1;

  // Operands captured at accept
  logic [WIDTH-1:0] op0, op1;
  logic             sign_q;
  logic             q_neg, r_neg;
  logic             div_dz, div_ovf;

  // Divider working registers
  logic [WIDTH-1:0] quo;       // dividend shifts out the top, quotient bits in at the bottom
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;

  logic accept;

  assign in_ready  = (state == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_res0  = res0;
  assign out_res1  = res1;

  // ---------------------------------------------------------------------------
  // Divide setup: magnitudes and loop length, computed from the live inputs so
  // they can be captured on the accept edge.
  // ---------------------------------------------------------------------------
  logic             src0_neg, src1_neg;
  logic [WIDTH-1:0] mag0, mag1, div_init;
  logic [CW-1:0]    div_steps;

  assign src0_neg = in_sign & in_src0[WIDTH-1];
  assign src1_neg = in_sign & in_src1[WIDTH-1];
  // The magnitude of the most negative value is 2**(WIDTH-1), which is still
  // exact when read as unsigned.
  assign mag0     = src0_neg ? -in_src0 : in_src0;
  assign mag1     = src1_neg ? -in_src1 : in_src1;

`ifdef MULDIV_EARLY_OUT_EN
  function automatic logic [CW-1:0] count_lz(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n     = n + CW'(1);
      end
    end
    return n;
  endfunction

  logic [CW-1:0] lz;

  assign lz = count_lz(mag0);
  // A zero dividend still runs one step so it leaves through the same path.
  assign div_steps = (lz == CW'(WIDTH)) ? CW'(1) : CW'(WIDTH) - lz;
  assign div_init  = mag0 << lz;
`else
  assign div_steps = CW'(WIDTH);
  assign div_init  = mag0;
`endif

  // ---------------------------------------------------------------------------
  // One restoring step. rem < dvs always holds, so the trial difference fits in
  // WIDTH+1 bits as two's complement; a set shifted-out bit means the partial
  // remainder already exceeds any WIDTH-bit divisor.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] rem_sh, trial;
  logic           ge;

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs};
  assign ge     = rem_sh[WIDTH] | ~trial[WIDTH];

  // ---------------------------------------------------------------------------
  // Multiply: extend both operands to 2*WIDTH; the low 2*WIDTH bits of the
  // product are then correct for both signed and unsigned operands.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] ext0, ext1, prod;

  assign ext0 = {{WIDTH{sign_q & op0[WIDTH-1]}}, op0};
  assign ext1 = {{WIDTH{sign_q & op1[WIDTH-1]}}, op1};
  assign prod = ext0 * ext1;

  // ---------------------------------------------------------------------------
  // Control and result registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values and the block simulates exactly like the flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      res0  <= '0;
      res1  <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (in_op)
              OP_MUL: begin
                state <= MUL;
                cnt   <= CW'(MUL_STAGES - 1);
              end
              OP_DIV: begin
                state <= DIV;
                cnt   <= div_steps;
              end
              default: ;  // nop and reserved complete the handshake only
            endcase
          end
        end
        MUL: begin
          if (cnt == '0) begin
            state        <= DONE;
            {res1, res0} <= prod;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DIV: begin
          if (div_dz) begin
            state <= DONE;
            res0  <= '1;
            res1  <= op0;
          end else if (div_ovf) begin
            state <= DONE;
            res0  <= op0;
            res1  <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= DONE;
            res0  <= q_neg ? -quo : quo;
            res1  <= r_neg ? -rem : rem;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture and divider datapath
  // ---------------------------------------------------------------------------
  // NOTE: these registers carry no reset; every field is loaded on accept
  // before it is read, and the control block alone decides what is visible.
  always_ff @(posedge clock) begin
    if (accept) begin
      op0     <= in_src0;
      op1     <= in_src1;
      sign_q  <= in_sign;
      q_neg   <= src0_neg ^ src1_neg;
      r_neg   <= src0_neg;
      div_dz  <= (in_src1 == '0);
      div_ovf <= in_sign && (in_src0 == MOST_NEG) && (&in_src1);
      quo     <= div_init;
      rem     <= '0;
      dvs     <= mag1;
    end else if (state == DIV && cnt != '0) begin
      quo <= {quo[WIDTH-2:0], ge};
      rem <= ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_muldiv_engine.sv
// -----------------------------------------------------------------------------
// tb_muldiv_engine
//
// Self-checking bench for muldiv_engine (WIDTH=32, MUL_STAGES=2). Expected
// results and latencies come from a plain-arithmetic model; one monitor
// process compares the outputs against the queue of expected results on every
// cycle out_valid is high. Directed cases pin known values; the rest is
// randomized with a bias toward the divide corner cases.
// -----------------------------------------------------------------------------
module tb_muldiv_engine;

  localparam int W = 32;
  localparam int S = 2;

  logic          clock;
  logic          reset;
  logic          flush;
  logic [W-1:0]  in_src0, in_src1;
  logic [1:0]    in_op;
  logic          in_sign;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res0, out_res1;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [2*W-1:0] exp_q[$];

  muldiv_engine #(.WIDTH(W), .MUL_STAGES(S)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_src0   (in_src0),
    .in_src1   (in_src1),
    .in_op     (in_op),
    .in_sign   (in_sign),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res0  (out_res0),
    .out_res1  (out_res1),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: {res1, res0}
  function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic s);
    longint x, y;
    if (op == 2'd1) begin
      if (s) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
      end
      return {32'b0, a} * {32'b0, b};
    end
    if (b == '0) return {a, 32'hFFFF_FFFF};
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      return {32'(x % y), 32'(x / y)};
    end
    return {a % b, a / b};
  endfunction

  // Cycles from the accept edge to the edge after which out_valid is high
  function automatic int model_lat(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic s);
    if (op == 2'd1) return S;
    if (b == '0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    begin
      logic [W-1:0] m;
      int           bits;
      m    = (s && a[W-1]) ? -a : a;
      bits = 1;
      for (int i = 0; i < W; i++) if (m[i]) bits = i + 1;
      return bits + 1;
    end
`else
    return W + 1;
`endif
  endfunction

  // Monitor: every cycle a result is presented it must match the oldest
  // expected result; it leaves the queue when the consumer takes it.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (!reset && !flush && out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious out_valid", 64'(out_valid), 64'(0));
        end else begin
          check("result", {out_res1, out_res0}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Present a request and complete the handshake. Returns at the falling
  // edge just after the accept edge, with the inputs scrambled.
  task automatic accept_op(input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic s);
    int guard;
    guard = 0;
    @(negedge clock);
    in_op    = op;
    in_src0  = a;
    in_src1  = b;
    in_sign  = s;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 100) begin
      @(negedge clock);
      #1;
      guard++;
    end
    if (guard >= 100) check("in_ready wait timeout", 64'(in_ready), 64'(1));
    @(posedge clock);
    if (op == 2'd1 || op == 2'd2) exp_q.push_back(model(op, a, b, s));
    @(negedge clock);
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_src0  = $urandom;
    in_src1  = $urandom;
    in_sign  = 1'($urandom);
  endtask

  // Wait for the result, check its latency, optionally stall the consumer,
  // then consume it and check the one-cycle out_valid pulse.
  task automatic wait_result(input int exp_lat, input int hold, input bit rand_ready,
                             output logic [2*W-1:0] got);
    int lat, g, h;
    lat = 0;
    g   = 0;
    h   = 0;
    #1;
    while (!out_valid && lat < 200) begin
      @(negedge clock);
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    got = {out_res1, out_res0};
    while (!out_ready && g < 60) begin
      if (hold > 0) begin
        check("hold in_ready", 64'(in_ready), 64'(0));
        check("hold out_valid", 64'(out_valid), 64'(1));
        check("hold result", {out_res1, out_res0}, got);
      end
      @(negedge clock);
      if (h < hold - 1)    out_ready = 1'b0;
      else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      else                 out_ready = 1'b1;
      h++;
      #1;
      g++;
    end
    @(posedge clock);
    @(negedge clock);
    #1;
    check("out_valid one pulse", 64'(out_valid), 64'(0));
    check("in_ready after consume", 64'(in_ready), 64'(1));
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input int exp_lat, input int hold,
                        input bit rand_ready, output logic [2*W-1:0] got);
    accept_op(op, a, b, s);
    if (op == 2'd1 || op == 2'd2) begin
      wait_result(exp_lat, hold, rand_ready, got);
    end else begin
      got = '0;
      #1;
      check("nop busy", 64'(busy), 64'(0));
      check("nop in_ready", 64'(in_ready), 64'(1));
    end
  endtask

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_5_1 = 4;
  localparam int LAT_0_3 = 2;
`else
  localparam int LAT_5_1 = 33;
  localparam int LAT_0_3 = 33;
`endif

  initial begin
    logic [2*W-1:0] got;
    logic [1:0]     op;
    logic [W-1:0]   a, b;
    logic           s;
    int             r;

    reset     = 1'b1;
    flush     = 1'b0;
    in_src0   = '0;
    in_src1   = '0;
    in_op     = 2'd0;
    in_sign   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset in_ready", 64'(in_ready), 64'(1));
    check("reset results", {out_res1, out_res0}, 64'(0));
    reset = 1'b0;

    // Directed cases pinned to hand-computed values
    run_op(2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 2, 0, 1'b0, got);
    check("signed mul", got, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 2, 0, 1'b0, got);
    check("unsigned mul", got, 64'h0000_0006_FFFF_FFEB);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, model_lat(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1), 0, 1'b0, got);
    check("signed div -7/2", got, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd2, 32'd100, 32'd7, 1'b0, model_lat(2'd2, 32'd100, 32'd7, 1'b0), 0, 1'b0, got);
    check("unsigned div 100/7", got, {32'd2, 32'd14});
    run_op(2'd2, 32'h1234_5678, 32'd0, 1'b1, 1, 0, 1'b0, got);
    check("div by zero", got, 64'h1234_5678_FFFF_FFFF);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 0, 1'b0, got);
    check("signed overflow", got, 64'h0000_0000_8000_0000);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, model_lat(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0), 0, 1'b0, got);
    check("unsigned 80000000/ffffffff", got, 64'h8000_0000_0000_0000);
    run_op(2'd2, 32'd5, 32'd1, 1'b0, LAT_5_1, 0, 1'b0, got);
    check("div 5/1", got, {32'd0, 32'd5});
    run_op(2'd2, 32'd0, 32'd3, 1'b1, LAT_0_3, 0, 1'b0, got);
    check("div 0/3", got, 64'd0);

    // Consumer stalls for five cycles after a multiply result
    out_ready = 1'b0;
    run_op(2'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, 2, 5, 1'b0, got);
    check("stalled mul", got, 64'h0000_0001_0000_0000);
    out_ready = 1'b1;

    // nop and reserved ops complete the handshake without a result
    run_op(2'd0, 32'd1, 32'd2, 1'b0, 0, 0, 1'b0, got);
    run_op(2'd3, 32'd1, 32'd2, 1'b0, 0, 0, 1'b0, got);
    repeat (4) begin
      @(negedge clock);
      #1;
      check("idle after nop", 64'(busy), 64'(0));
    end

    // Flush in the tenth cycle of a divide; a request offered alongside the
    // flush must not be taken.
    accept_op(2'd2, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clock);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 2'd1;
    exp_q.delete();
    #1;
    check("in_ready during flush", 64'(in_ready), 64'(0));
    @(negedge clock);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("busy after flush", 64'(busy), 64'(0));
    check("out_valid after flush", 64'(out_valid), 64'(0));
    repeat (2) @(negedge clock);
    #1;
    check("in_ready after flush", 64'(in_ready), 64'(1));
    repeat (30) begin
      @(negedge clock);
      #1;
      check("flushed div silent", 64'(out_valid), 64'(0));
    end
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2, 0, 1'b0, got);
    check("mul after flush", got, 64'd1);

    // Reset in the middle of a divide
    accept_op(2'd2, 32'hDEAD_BEEF, 32'd17, 1'b0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    #1;
    check("mid-div reset out_valid", 64'(out_valid), 64'(0));
    check("mid-div reset busy", 64'(busy), 64'(0));
    check("mid-div reset in_ready", 64'(in_ready), 64'(1));
    check("mid-div reset results", {out_res1, out_res0}, 64'(0));
    reset = 1'b0;

    // Randomized operations with a randomly stalling consumer
    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'd1 : (r < 9) ? 2'd2 : ($urandom_range(0, 1) != 0 ? 2'd0 : 2'd3);
      a  = $urandom;
      b  = $urandom;
      s  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = $urandom_range(1, 15);
        1: b = '0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = $urandom_range(0, 255);
        default: ;
      endcase
      run_op(op, a, b, s, model_lat(op, a, b, s), 0, 1'b1, got);
      out_ready = 1'b1;
    end

    check("expected queue drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
